// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StHiloWait = 2'd1,
      StFlush    = 2'd2
   } hz_state_e;

   localparam logic [4:0]  ZERO_REG = 5'd0;
   localparam int unsigned CNT_W    = 4;

   // Load-use: the load in EX writes a register the ID instruction reads; $0 never hazards.
   function automatic logic lu_hazard(input logic       ex_mem_read,
                                      input logic [4:0] ex_rt,
                                      input logic [4:0] id_rs,
                                      input logic [4:0] id_rt,
                                      input logic       id_uses_rt);
      return ex_mem_read && (ex_rt != ZERO_REG) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/hazard_stall_counter.sv
// Loadable saturating down-counter shared by the HI/LO wait and flush sequences.
// Priority: clear > load > decrement; never decrements below zero.
module hazard_stall_counter
   import hazard_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             is_one_o
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage sequencer: load-use stalls, multi-cycle HI/LO waits and branch flushes.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int unsigned HILO_CYCLES  = 3,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  IDRsField,
   input  logic [4:0]  IDRtField,
   input  logic        IDUsesRt,
   input  logic        IDHiLoOp,
   input  logic        EXMemRead,
   input  logic [4:0]  EXRtField,
   input  logic        MEMBranchTaken,
   output logic        PCWriteOut,
   output logic        IFIDWriteOut,
   output logic        IDEXBubbleOut,
   output logic        FlushOut,
   output logic        BusyOut
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] StallCountOut,
   output logic [15:0] FlushCountOut
`endif
);

   localparam logic [CNT_W-1:0] HiloLoad  = CNT_W'(HILO_CYCLES - 1);
   localparam logic [CNT_W-1:0] FlushLoad = CNT_W'(FLUSH_CYCLES - 1);
   localparam bit               HiloWaits = (HILO_CYCLES > 1);
   localparam bit               FlushHold = (FLUSH_CYCLES > 1);

   hz_state_e        state_d, state_q;
   logic             lu;
   logic [CNT_W-1:0] cnt;
   logic             cnt_is_one;
   logic             cnt_done;
   logic             cnt_clr;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;

   assign lu = lu_hazard(EXMemRead, EXRtField, IDRsField, IDRtField, IDUsesRt);

   // A zero count in a wait state is unreachable, but treat it as done rather than lock up.
   assign cnt_done = cnt_is_one || (cnt == '0);

   hazard_stall_counter u_stall_counter (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .cnt_o      (cnt),
      .is_one_o   (cnt_is_one)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_clr      = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      unique case (state_q)
         StRun: begin
            if (MEMBranchTaken) begin
               state_d      = FlushHold ? StFlush : StRun;
               cnt_load     = FlushHold;
               cnt_clr      = !FlushHold;
               cnt_load_val = FlushLoad;
            end else if (lu) begin
               state_d = StRun;
            end else if (IDHiLoOp && HiloWaits) begin
               state_d      = StHiloWait;
               cnt_load     = 1'b1;
               cnt_load_val = HiloLoad;
            end
         end
         StHiloWait: begin
            if (MEMBranchTaken) begin
               state_d      = FlushHold ? StFlush : StRun;
               cnt_load     = FlushHold;
               cnt_clr      = !FlushHold;
               cnt_load_val = FlushLoad;
            end else if (cnt_done) begin
               state_d = StRun;
               cnt_clr = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StFlush: begin
            if (MEMBranchTaken) begin
               cnt_load     = 1'b1;
               cnt_load_val = FlushLoad;
            end else if (cnt_done) begin
               state_d = StRun;
               cnt_clr = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = StRun;
            cnt_clr = 1'b1;
         end
      endcase
   end

   // Reset forces the run-state output values regardless of the registered state.
   always_comb begin
      PCWriteOut    = 1'b1;
      IFIDWriteOut  = 1'b1;
      IDEXBubbleOut = 1'b0;
      FlushOut      = 1'b0;
      BusyOut       = 1'b0;
      if (!Reset) begin
         BusyOut = (state_q != StRun);
         unique case (state_q)
            StRun: begin
               if (MEMBranchTaken) begin
                  FlushOut = 1'b1;
               end else if (lu) begin
                  PCWriteOut    = 1'b0;
                  IFIDWriteOut  = 1'b0;
                  IDEXBubbleOut = 1'b1;
               end
            end
            StHiloWait: begin
               if (MEMBranchTaken) begin
                  FlushOut = 1'b1;
               end else begin
                  PCWriteOut    = 1'b0;
                  IFIDWriteOut  = 1'b0;
                  IDEXBubbleOut = 1'b1;
               end
            end
            StFlush: begin
               FlushOut = 1'b1;
            end
            default: begin
               BusyOut = 1'b1;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_d, stall_cnt_q;
   logic [15:0] flush_cnt_d, flush_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!PCWriteOut && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (FlushOut && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCountOut = stall_cnt_q;
   assign FlushCountOut = flush_cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: default-parameter instance plus a FLUSH_CYCLES=2 / HILO_CYCLES=4 instance.
module tb_pipeline_hazard_controller;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [4:0] IDRsField, IDRtField, EXRtField;
   logic       IDUsesRt, IDHiLoOp, EXMemRead, MEMBranchTaken;

   logic pcw1, ifid1, bub1, fl1, busy1;
   logic pcw2, ifid2, bub2, fl2, busy2;
`ifdef HAZARD_STATS_EN
   logic [15:0] stall1, flushc1, stall2, flushc2;
`endif

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   pipeline_hazard_controller dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .IDRsField      (IDRsField),
      .IDRtField      (IDRtField),
      .IDUsesRt       (IDUsesRt),
      .IDHiLoOp       (IDHiLoOp),
      .EXMemRead      (EXMemRead),
      .EXRtField      (EXRtField),
      .MEMBranchTaken (MEMBranchTaken),
      .PCWriteOut     (pcw1),
      .IFIDWriteOut   (ifid1),
      .IDEXBubbleOut  (bub1),
      .FlushOut       (fl1),
      .BusyOut        (busy1)
`ifdef HAZARD_STATS_EN
      ,
      .StallCountOut  (stall1),
      .FlushCountOut  (flushc1)
`endif
   );

   pipeline_hazard_controller #(
      .HILO_CYCLES  (4),
      .FLUSH_CYCLES (2)
   ) dut2 (
      .Clk            (Clk),
      .Reset          (Reset),
      .IDRsField      (IDRsField),
      .IDRtField      (IDRtField),
      .IDUsesRt       (IDUsesRt),
      .IDHiLoOp       (IDHiLoOp),
      .EXMemRead      (EXMemRead),
      .EXRtField      (EXRtField),
      .MEMBranchTaken (MEMBranchTaken),
      .PCWriteOut     (pcw2),
      .IFIDWriteOut   (ifid2),
      .IDEXBubbleOut  (bub2),
      .FlushOut       (fl2),
      .BusyOut        (busy2)
`ifdef HAZARD_STATS_EN
      ,
      .StallCountOut  (stall2),
      .FlushCountOut  (flushc2)
`endif
   );

   // Output vectors ordered {PCWrite, IFIDWrite, Bubble, Flush, Busy}.
   wire [4:0] o1 = {pcw1, ifid1, bub1, fl1, busy1};
   wire [4:0] o2 = {pcw2, ifid2, bub2, fl2, busy2};

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr_in();
      IDRsField      = '0;
      IDRtField      = '0;
      EXRtField      = '0;
      IDUsesRt       = 1'b0;
      IDHiLoOp       = 1'b0;
      EXMemRead      = 1'b0;
      MEMBranchTaken = 1'b0;
   endtask

   initial begin
      // Reset for two edges with every input high.
      Reset          = 1'b1;
      IDRsField      = 5'h1F;
      IDRtField      = 5'h1F;
      EXRtField      = 5'h1F;
      IDUsesRt       = 1'b1;
      IDHiLoOp       = 1'b1;
      EXMemRead      = 1'b1;
      MEMBranchTaken = 1'b1;
      #2 chk("reset_c0", o1, 5'b11000);
      tick(); #2 chk("reset_c1", o1, 5'b11000);
      tick(); Reset = 1'b0; clr_in();
      #2 chk("run_after_reset", o1, 5'b11000);
      chk("run_after_reset2", o2, 5'b11000);

      // Load-use on rs, release, $0, rt path.
      tick(); EXMemRead = 1'b1; EXRtField = 5'd8; IDRsField = 5'd8;
      #2 chk("lu_stall", o1, 5'b00100);
      tick(); EXMemRead = 1'b0;
      #2 chk("lu_release", o1, 5'b11000);
      tick(); EXMemRead = 1'b1; EXRtField = 5'd0; IDRsField = 5'd0;
      #2 chk("lu_zero_reg", o1, 5'b11000);
      tick(); EXRtField = 5'd9; IDRtField = 5'd9; IDRsField = 5'd3; IDUsesRt = 1'b1;
      #2 chk("lu_rt", o1, 5'b00100);
      tick(); IDUsesRt = 1'b0;
      #2 chk("lu_rt_unused", o1, 5'b11000);

      // HI/LO op, HILO_CYCLES=3: issue plus two wait cycles.
      tick(); clr_in(); IDHiLoOp = 1'b1;
      #2 chk("hilo_issue", o1, 5'b11000);
      tick(); IDHiLoOp = 1'b0;
      #2 chk("hilo_wait1", o1, 5'b00101);
      tick(); #2 chk("hilo_wait2", o1, 5'b00101);
      tick(); #2 chk("hilo_done", o1, 5'b11000);

      // Branch aborts the wait in its first cycle.
      tick(); IDHiLoOp = 1'b1;
      tick(); IDHiLoOp = 1'b0; MEMBranchTaken = 1'b1;
      #2 chk("abort_flush", o1, 5'b11011);
      tick(); MEMBranchTaken = 1'b0;
      #2 chk("abort_run", o1, 5'b11000);
      tick(); #2 chk("abort_no_residual", o1, 5'b11000);

      // LU and branch together: flush only.
      tick(); EXMemRead = 1'b1; EXRtField = 5'd8; IDRsField = 5'd8; MEMBranchTaken = 1'b1;
      #2 chk("lu_branch", o1, 5'b11010);
      tick(); clr_in();
      #2 chk("lu_branch_after", o1, 5'b11000);

      // LU and HI/LO together: stall first, then the HI/LO sequence.
      tick(); EXMemRead = 1'b1; EXRtField = 5'd8; IDRsField = 5'd8; IDHiLoOp = 1'b1;
      #2 chk("lu_hilo_stall", o1, 5'b00100);
      tick(); EXMemRead = 1'b0;
      #2 chk("lu_hilo_issue", o1, 5'b11000);
      tick(); IDHiLoOp = 1'b0;
      #2 chk("lu_hilo_wait1", o1, 5'b00101);
      tick(); #2 chk("lu_hilo_wait2", o1, 5'b00101);
      tick(); #2 chk("lu_hilo_done", o1, 5'b11000);

      // Reset in the middle of a HI/LO wait leaves no residual stall.
      tick(); clr_in(); IDHiLoOp = 1'b1;
      tick(); IDHiLoOp = 1'b0;
      #2 chk("rst_mid_pre", o1, 5'b00101);
      Reset = 1'b1;
      #1 chk("rst_mid_in", o1, 5'b11000);
      tick(); Reset = 1'b0;
      #2 chk("rst_mid_after", o1, 5'b11000);
      tick(); #2 chk("rst_mid_no_residual", o1, 5'b11000);

      // Second instance: two-cycle flush, then a three-cycle HI/LO wait.
      tick(); Reset = 1'b1;
      tick(); Reset = 1'b0; clr_in();
`ifdef HAZARD_STATS_EN
      #1 chk16("stats_stall_reset", stall2, 16'd0);
      chk16("stats_flush_reset", flushc2, 16'd0);
      #1;
`else
      #2;
`endif
      MEMBranchTaken = 1'b1;
      #1 chk("f2_branch", o2, 5'b11010);
      tick(); MEMBranchTaken = 1'b0; EXMemRead = 1'b1; EXRtField = 5'd8; IDRsField = 5'd8;
      IDHiLoOp = 1'b1;
      #2 chk("f2_flush_hold", o2, 5'b11011);
      tick(); clr_in();
      #2 chk("f2_done", o2, 5'b11000);
`ifdef HAZARD_STATS_EN
      chk16("stats_flush2", flushc2, 16'd2);
`endif
      IDHiLoOp = 1'b1;
      #1 chk("f2_hilo_issue", o2, 5'b11000);
      tick(); IDHiLoOp = 1'b0;
      #2 chk("f2_wait1", o2, 5'b00101);
      tick(); #2 chk("f2_wait2", o2, 5'b00101);
      tick(); #2 chk("f2_wait3", o2, 5'b00101);
      tick(); #2 chk("f2_hilo_done", o2, 5'b11000);
`ifdef HAZARD_STATS_EN
      chk16("stats_stall3", stall2, 16'd3);
      chk16("stats_flush_hold", flushc2, 16'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
